// File: rtl/md_scheduler_pkg.sv
// rtl/md_scheduler_pkg.sv - op codes and state encodings shared by the mult/div sequencer.
package md_scheduler_pkg;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6,
      MD_READ  = 3'd7
   } md_op_e;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

   localparam logic [31:0] MD_ALL_ONES = 32'hFFFF_FFFF;
   localparam logic [31:0] MD_INT_MIN  = 32'h8000_0000;

   function automatic logic md_is_mul(input md_op_e op);
      return (op == MD_MULT) || (op == MD_MULTU);
   endfunction

   function automatic logic md_is_div(input md_op_e op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_arith.sv
// rtl/md_arith.sv - combinational product/quotient unit producing the HI/LO result pair.
// Divide-by-zero and INT_MIN/-1 are resolved here so the sequencer only latches results.
module md_arith
   import md_scheduler_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo
);

   logic signed [63:0] prod_s;
   logic [63:0]        prod_u;
   logic signed [31:0] quot_s;
   logic signed [31:0] rem_s;
   logic [31:0]        quot_u;
   logic [31:0]        rem_u;
   logic               div_zero;
   logic               div_ovf;
   md_op_e             op_e;

   assign op_e     = md_op_e'(op);
   assign prod_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
   assign prod_u   = {32'd0, a} * {32'd0, b};
   assign quot_s   = $signed(a) / $signed(b);
   assign rem_s    = $signed(a) % $signed(b);
   assign quot_u   = a / b;
   assign rem_u    = a % b;
   assign div_zero = (b == 32'd0);
   assign div_ovf  = (a == MD_INT_MIN) && (b == MD_ALL_ONES);

   always_comb begin
      res_hi = 32'd0;
      res_lo = 32'd0;
      case (op_e)
         MD_MULT: begin
            res_hi = prod_s[63:32];
            res_lo = prod_s[31:0];
         end
         MD_MULTU: begin
            res_hi = prod_u[63:32];
            res_lo = prod_u[31:0];
         end
         MD_DIV: begin
            if (div_zero) begin
               res_hi = a;
               res_lo = MD_ALL_ONES;
            end else if (div_ovf) begin
               res_hi = 32'd0;
               res_lo = MD_INT_MIN;
            end else begin
               res_hi = rem_s;
               res_lo = quot_s;
            end
         end
         MD_DIVU: begin
            if (div_zero) begin
               res_hi = a;
               res_lo = MD_ALL_ONES;
            end else begin
               res_hi = rem_u;
               res_lo = quot_u;
            end
         end
         default: begin
            res_hi = 32'd0;
            res_lo = 32'd0;
         end
      endcase
   end

endmodule

// File: rtl/md_scheduler.sv
// rtl/md_scheduler.sv - multi-cycle mult/div sequencer owning the HI/LO pair.
// Optional MD_CANCEL_EN adds a cancel input that abandons an in-flight op.
module md_scheduler
   import md_scheduler_pkg::*;
#(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        issue,
`ifdef MD_CANCEL_EN
   input  logic        cancel,
`endif
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        done
);

   localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   md_state_e          state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [31:0]        hi_q, hi_d;
   logic [31:0]        lo_q, lo_d;
   logic [31:0]        pend_hi_q, pend_hi_d;
   logic [31:0]        pend_lo_q, pend_lo_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [31:0]        res_hi;
   logic [31:0]        res_lo;
   logic               cancel_req;
   md_op_e             op_e;

   assign op_e = md_op_e'(op);

`ifdef MD_CANCEL_EN
   assign cancel_req = cancel;
`else
   assign cancel_req = 1'b0;
`endif

   md_arith u_arith (
      .op     (op),
      .a      (a),
      .b      (b),
      .res_hi (res_hi),
      .res_lo (res_lo)
   );

   // Stall only when a real md op meets an in-flight one; bubbles pass freely.
   assign stall = issue && (op_e != MD_NONE) && busy_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign hi    = hi_q;
   assign lo    = lo_q;

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      case (state_q)
         MD_IDLE: begin
            if (issue) begin
               if (md_is_mul(op_e)) begin
                  pend_hi_d = res_hi;
                  pend_lo_d = res_lo;
                  count_d   = CNT_W'(MUL_CYCLES);
                  state_d   = MD_BUSY;
                  busy_d    = 1'b1;
               end else if (md_is_div(op_e)) begin
                  pend_hi_d = res_hi;
                  pend_lo_d = res_lo;
                  count_d   = CNT_W'(DIV_CYCLES);
                  state_d   = MD_BUSY;
                  busy_d    = 1'b1;
               end else if (op_e == MD_MTHI) begin
                  hi_d = a;
               end else if (op_e == MD_MTLO) begin
                  lo_d = a;
               end
            end
         end
         MD_BUSY: begin
            // Cancel beats a commit landing on the same edge.
            if (cancel_req) begin
               state_d   = MD_IDLE;
               busy_d    = 1'b0;
               count_d   = '0;
               pend_hi_d = 32'd0;
               pend_lo_d = 32'd0;
            end else if (count_q == CNT_W'(1)) begin
               hi_d    = pend_hi_q;
               lo_d    = pend_lo_q;
               done_d  = 1'b1;
               state_d = MD_IDLE;
               busy_d  = 1'b0;
               count_d = '0;
            end else begin
               count_d = count_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = MD_IDLE;
            busy_d  = 1'b0;
            count_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= MD_IDLE;
         count_q   <= '0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         pend_hi_q <= 32'd0;
         pend_lo_q <= 32'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

endmodule

// File: tb/tb_md_scheduler.sv
// tb/tb_md_scheduler.sv - self-checking bench for md_scheduler against a behavioural HI/LO model.
module tb_md_scheduler;
   import md_scheduler_pkg::*;

   localparam int MUL_N = 5;
   localparam int DIV_N = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        issue = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        cancel = 1'b0;
   logic        busy;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        done;

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;

   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;
   logic [31:0] m_ph = 32'd0;
   logic [31:0] m_pl = 32'd0;
   int          m_rem = 0;
   logic        m_done = 1'b0;

   md_scheduler #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
      .clk    (clk),
      .reset  (reset),
      .issue  (issue),
`ifdef MD_CANCEL_EN
      .cancel (cancel),
`endif
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .stall  (stall),
      .hi     (hi),
      .lo     (lo),
      .done   (done)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      longint          sx, sy, q, r;
      longint unsigned ux, uy, uq, ur;
      logic [63:0]     res;
      sx  = longint'($signed(x));
      sy  = longint'($signed(y));
      ux  = {32'd0, x};
      uy  = {32'd0, y};
      res = 64'd0;
      case (o)
         MD_MULT:  res = 64'(sx * sy);
         MD_MULTU: res = ux * uy;
         MD_DIV: begin
            if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
            else begin
               q = sx / sy;
               r = sx % sy;
               res = {r[31:0], q[31:0]};
            end
         end
         MD_DIVU: begin
            if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
            else begin
               uq = ux / uy;
               ur = ux % uy;
               res = {ur[31:0], uq[31:0]};
            end
         end
         default: res = 64'd0;
      endcase
      return res;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int g = 0;
      while (busy && g < 200) begin
         step();
         g++;
      end
      chk1("wait_idle_bound", busy, 1'b0);
   endtask

   task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      issue = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      step();
      issue = 1'b0;
      a     = $urandom;
      b     = $urandom;
      wait_idle();
   endtask

   initial begin
      int n;
      int d0;
      fork
         forever begin
            @(posedge clk);
            if (!reset) begin
               m_hi = 32'd0; m_lo = 32'd0; m_rem = 0; m_done = 1'b0;
            end else begin
               m_done = 1'b0;
               if (m_rem > 0) begin
`ifdef MD_CANCEL_EN
                  if (cancel) m_rem = 0;
                  else
`endif
                  if (m_rem == 1) begin
                     m_hi = m_ph; m_lo = m_pl; m_done = 1'b1; m_rem = 0;
                  end else m_rem--;
               end else if (issue) begin
                  case (op)
                     MD_MULT, MD_MULTU: begin {m_ph, m_pl} = ref_result(op, a, b); m_rem = MUL_N; end
                     MD_DIV, MD_DIVU:   begin {m_ph, m_pl} = ref_result(op, a, b); m_rem = DIV_N; end
                     MD_MTHI: m_hi = a;
                     MD_MTLO: m_lo = a;
                     default: ;
                  endcase
               end
            end
         end
         forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (reset) begin
               chk1("cyc_busy", busy, m_rem > 0);
               chk("cyc_hi", hi, m_hi);
               chk("cyc_lo", lo, m_lo);
               chk1("cyc_done", done, m_done);
               chk1("cyc_stall", stall, issue && (op != 3'd0) && (m_rem > 0));
            end
         end
      join_none

      step();
      step();
      chk1("rst_busy", busy, 1'b0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk1("rst_done", done, 1'b0);
      reset = 1'b1;
      step();

      d0 = done_cnt;
      issue = 1'b1; op = MD_MULT; a = 32'hFFFF_FFFE; b = 32'd3;
      step();
      issue = 1'b0;
      n = 0;
      while (busy && n < 50) begin
         n++;
         step();
      end
      chk("mult_busy_cycles", 32'(n), 32'd5);
      chk("mult_hi", hi, 32'hFFFF_FFFF);
      chk("mult_lo", lo, 32'hFFFF_FFFA);
      chk("model_mult_lo", m_lo, 32'hFFFF_FFFA);
      chk1("mult_done", done, 1'b1);
      step();
      chk1("mult_done_drop", done, 1'b0);
      chk("mult_done_count", 32'(done_cnt - d0), 32'd1);

      issue = 1'b1; op = MD_DIVU; a = 32'd100; b = 32'd7;
      step();
      issue = 1'b0;
      step();
      issue = 1'b1; op = MD_READ;
      #1;
      chk1("read_stall", stall, 1'b1);
      wait_idle();
      chk1("read_stall_clear", stall, 1'b0);
      chk("divu_hi", hi, 32'd2);
      chk("divu_lo", lo, 32'd14);
      chk("model_divu_lo", m_lo, 32'd14);
      issue = 1'b0;

      run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("div_ovf_lo", lo, 32'h8000_0000);
      chk("div_ovf_hi", hi, 32'd0);
      run_op(MD_DIV, 32'd5, 32'd0);
      chk("div0_lo", lo, 32'hFFFF_FFFF);
      chk("div0_hi", hi, 32'd5);
      run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2);
      chk("divneg_lo", lo, 32'hFFFF_FFFD);
      chk("divneg_hi", hi, 32'hFFFF_FFFF);
      chk("model_divneg_hi", m_hi, 32'hFFFF_FFFF);
      run_op(MD_DIVU, 32'd9, 32'd0);
      chk("divu0_lo", lo, 32'hFFFF_FFFF);
      chk("divu0_hi", hi, 32'd9);

      issue = 1'b1; op = MD_MTHI; a = 32'h1234_5678;
      step();
      issue = 1'b0;
      chk("mthi_hi", hi, 32'h1234_5678);
      chk1("mthi_busy", busy, 1'b0);
      issue = 1'b1; op = MD_DIV; a = 32'd20; b = 32'd3;
      step();
      op = MD_MTLO; a = 32'hCAFE_F00D;
      #1;
      chk1("mtlo_stall", stall, 1'b1);
      wait_idle();
      chk("div_before_mtlo_lo", lo, 32'd6);
      chk("div_before_mtlo_hi", hi, 32'd2);
      step();
      issue = 1'b0;
      chk("mtlo_lo", lo, 32'hCAFE_F00D);

      d0 = done_cnt;
      issue = 1'b1; op = MD_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
      step();
      issue = 1'b0;
      step();
      step();
      reset = 1'b0;
      #1;
      chk("rstmid_hi", hi, 32'd0);
      chk("rstmid_lo", lo, 32'd0);
      chk1("rstmid_busy", busy, 1'b0);
      chk1("rstmid_done", done, 1'b0);
      step();
      reset = 1'b1;
      repeat (8) step();
      chk("rstmid_no_done", 32'(done_cnt - d0), 32'd0);

`ifdef MD_CANCEL_EN
      issue = 1'b1; op = MD_MTHI; a = 32'd1;
      step();
      op = MD_MTLO; a = 32'd2;
      step();
      d0 = done_cnt;
      op = MD_MULT; a = 32'd3; b = 32'd4;
      step();
      issue = 1'b0;
      step();
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      chk1("cancel_busy", busy, 1'b0);
      chk("cancel_hi", hi, 32'd1);
      chk("cancel_lo", lo, 32'd2);
      repeat (8) step();
      chk("cancel_no_done", 32'(done_cnt - d0), 32'd0);
`endif

      for (int i = 0; i < 3000; i++) begin
         issue = ($urandom_range(0, 3) != 0);
         op    = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 7))
            0: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            1: begin a = $urandom; b = 32'd0; end
            2: begin a = 32'($urandom_range(0, 200)); b = 32'($urandom_range(1, 20)); end
            3: begin a = -32'($urandom_range(0, 200)); b = 32'($urandom_range(1, 20)); end
            default: begin a = $urandom; b = $urandom; end
         endcase
`ifdef MD_CANCEL_EN
         cancel = ($urandom_range(0, 15) == 0);
`endif
         if ($urandom_range(0, 499) == 0) begin
            reset = 1'b0;
            step();
            reset = 1'b1;
         end
         step();
      end
      issue = 1'b0;
      cancel = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/md_scheduler.md
Name: md_scheduler

Overview:
- Multi-cycle multiply/divide sequencer with the HI/LO register pair, sitting beside the ALU in the Execution stage.
- Accepts one mult/div/move-to-HI/LO op per issue and counts down a fixed latency before committing HI/LO.
- Raises a stall request while a new mult/div/HI/LO-access op would collide with an in-flight one; top level ORs this stall into the Execution stall level.

Parameters:
MUL_CYCLES, 5, busy cycles for MULT/MULTU (minimum 1)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (minimum 1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
issue  in  1  E-stage op valid (not bubble, not stalled by another source)
op  in  3  `mdNone/`mdMult/`mdMultu/`mdDiv/`mdDivu/`mdMthi/`mdMtlo/`mdRead
a  in  32  rs operand (forwarded value)
b  in  32  rt operand (forwarded value)
busy  out  1  operation in flight
stall  out  1  combinational: issue && op!=`mdNone && busy
hi  out  32  architectural HI
lo  out  32  architectural LO
done  out  1  one-cycle pulse on the edge HI/LO commit from a mult/div

Behaviour:
- Reset (reset==0, async): state=IDLE; count=0; hi=lo=0; busy=0; done=0; pending regs=0.
- States: IDLE, BUSY.
- IDLE, issue && !stall:
  - MULT/MULTU: latch the 64-bit product (signed or unsigned) into pending_hi/pending_lo; count<=MUL_CYCLES; go to BUSY.
  - DIV/DIVU: pending_lo<=quotient, pending_hi<=remainder; count<=DIV_CYCLES; go to BUSY.
  - MTHI/MTLO: hi (or lo) <= a at the next edge; stay IDLE; busy stays 0.
  - `mdRead: no state change; hi/lo are read combinationally by the E stage.
- BUSY: busy=1. Each edge decrements count. At the edge where count==1: hi<=pending_hi, lo<=pending_lo, done<=1 for one cycle, state<=IDLE.
- Latency: op issued at edge t drives busy high for cycles t+1 through t+N. New hi/lo and busy=0 appear together after edge t+N.
- Issue while BUSY:
  - stall=1; operation not accepted; state and count untouched.
  - The pipeline holds the instruction and retries; it is accepted in the first IDLE cycle.
- Issue with op==`mdNone never stalls.
- Division rules:
  - Signed division truncates toward zero; remainder takes the sign of the dividend.
  - Divide by zero: lo=32'hFFFFFFFF, hi=a, for both signed and unsigned.
  - Signed overflow (0x80000000 / -1): lo=0x80000000, hi=0.
- Operands are captured at issue; later changes on a/b while BUSY have no effect.
- Reset asserted mid-operation: operation discarded immediately; hi=lo=0; no done pulse.

Optional Feature:
- Macro: MD_CANCEL_EN
- Defined:
  - Extra input port cancel (1 bit).
  - cancel==1 while BUSY: state<=IDLE at the next edge; pending discarded; hi/lo keep their pre-issue values; no done pulse.
  - cancel in the same cycle as the commit edge (count==1): cancel wins, no commit.
  - cancel while IDLE: no effect; an issue in the same cycle is still accepted.
- Not defined: port absent; every accepted operation always commits.

Decomposition:
- constants.v: op codes `mdNone..`mdRead (3-bit); state encodings `mdIdle/`mdBusy.
- Sub-module md_arith: purely combinational; inputs op, a, b; outputs res_hi, res_lo; contains the signed/unsigned product and quotient plus the divide-by-zero and overflow rules.
- md_scheduler holds the FSM, the counter and the HI/LO registers.

Test Plan:
1. MULT a=0xFFFFFFFE(-2), b=3 with MUL_CYCLES=5 -> busy for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulses once.
2. DIVU a=100, b=7, then issue `mdRead on cycle 2 of busy -> stall=1 until busy drops; then hi=2, lo=14.
3. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. Then DIV a=5, b=0 -> lo=0xFFFFFFFF, hi=5.
4. MTHI a=0x12345678 while IDLE -> hi=0x12345678 next cycle, busy never asserts. MTLO issued while a DIV is busy -> stalled, applied only after the DIV commit.
5. MULTU a=b=0xFFFFFFFF, reset pulled low at busy cycle 3 -> hi=lo=0 immediately, busy=0, no done pulse.
6. (MD_CANCEL_EN) MULT a=3, b=4 over prior hi=1, lo=2; cancel on busy cycle 2 -> IDLE next cycle; hi=1, lo=2; done never pulses.
